// File: rtl/pingpong_pkg.sv
// Shared types and default geometry for the ping-pong buffer scheduler.
package pingpong_pkg;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_ADDRW = 3;
   localparam int DEF_LANES = 4;
   localparam int SELW      = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_PINGPONG,
      ST_DRAIN,
      ST_DONE
   } state_t;
endpackage

// File: rtl/pingpong_sched_bank_counter.sv
// Wrapping up-counter with synchronous clear; term flags the last value.
module bank_counter #(
   parameter int W    = 3,
   parameter int LAST = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         term
);
   localparam logic [W-1:0] LAST_V = W'(LAST);

   assign term = (count == LAST_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= term ? '0 : count + W'(1);
   end
endmodule

// File: rtl/pingpong_sched.sv
// Ping-pong A/B bank scheduler: write-bank fill, lane-steered read drain, swap.
// state    | meaning
// IDLE     | waiting for start & lock
// FILL     | first bank filling, nothing to read yet
// PINGPONG | writing one bank while draining the other
// DRAIN    | stop seen: draining the last full bank, write side idle
// DONE     | one-cycle completion pulse
module pingpong_sched
   import pingpong_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDRW = DEF_ADDRW,
   parameter int LANES = DEF_LANES
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             lock,
   input  logic             stop,
   input  logic             wrvalid,
   input  logic             rdready,
   output logic             wa,
   output logic             ena,
   output logic             enb,
   output logic             enwr,
   output logic             enrd,
   output logic [ADDRW-1:0] wraddr,
   output logic [ADDRW-1:0] rdaddr,
   output logic [SELW-1:0]  selectline,
   output logic             ensteer,
   output logic             resetaddr,
   output logic             complete
);
   state_t state, state_nx;
   logic   wrfull, rdempty, stop_q;
   logic   swap, go, clr;
   logic   wr_phase, rd_phase;
   logic   wr_tc, rd_tc, sel_tc;

   assign wr_phase = (state == ST_FILL) || (state == ST_PINGPONG);
   assign rd_phase = (state == ST_PINGPONG) || (state == ST_DRAIN);

   assign enwr    = lock & wrvalid & ~wrfull & wr_phase;
   assign ensteer = lock & rdready & ~rdempty & rd_phase;
   assign enrd    = ensteer & (selectline == '0);
   assign ena     = wa ? enwr : enrd;
   assign enb     = wa ? enrd : enwr;
   assign clr     = swap | go;

   bank_counter #(.W(ADDRW), .LAST(DEPTH-1)) u_wr_cnt (
      .clk(clk), .rst_n(resetn), .en(enwr), .clr(clr),
      .count(wraddr), .term(wr_tc)
   );

   bank_counter #(.W(ADDRW), .LAST(DEPTH-1)) u_rd_cnt (
      .clk(clk), .rst_n(resetn), .en(ensteer & sel_tc), .clr(clr),
      .count(rdaddr), .term(rd_tc)
   );

   bank_counter #(.W(SELW), .LAST(LANES-1)) u_sel_cnt (
      .clk(clk), .rst_n(resetn), .en(ensteer), .clr(clr),
      .count(selectline), .term(sel_tc)
   );

   // DONE always falls back to IDLE so complete can never stretch past one cycle.
   always_comb begin
      state_nx = state;
      swap     = 1'b0;
      go       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (lock && start) begin
               go       = 1'b1;
               state_nx = ST_FILL;
            end
         end
         ST_FILL: begin
            if (lock && wrfull) begin
               swap     = 1'b1;
               state_nx = stop_q ? ST_DRAIN : ST_PINGPONG;
            end
         end
         ST_PINGPONG: begin
            if (lock && wrfull && rdempty) begin
               swap     = 1'b1;
               state_nx = stop_q ? ST_DRAIN : ST_PINGPONG;
            end
         end
         ST_DRAIN: begin
            if (lock && rdempty)
               state_nx = ST_DONE;
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         wa        <= 1'b1;
         wrfull    <= 1'b0;
         rdempty   <= 1'b0;
         stop_q    <= 1'b0;
         resetaddr <= 1'b0;
         complete  <= 1'b0;
      end else begin
         state     <= state_nx;
         resetaddr <= swap;
         complete  <= lock & rdempty & (state == ST_DRAIN);
         if (swap)
            wa <= ~wa;
         if (clr)
            wrfull <= 1'b0;
         else if (enwr && wr_tc)
            wrfull <= 1'b1;
         if (clr)
            rdempty <= 1'b0;
         else if (ensteer && sel_tc && rd_tc)
            rdempty <= 1'b1;
         if (state == ST_IDLE)
            stop_q <= 1'b0;
         else if (lock && stop)
            stop_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pingpong_sched.sv
// Directed bench for pingpong_sched with a count-based reference model.
module tb_pingpong_sched;
   localparam int DEPTH = 8;
   localparam int ADDRW = 3;
   localparam int LANES = 4;
   localparam int TOTAL = DEPTH * LANES;

   localparam int PH_IDLE  = 0;
   localparam int PH_FILL  = 1;
   localparam int PH_PP    = 2;
   localparam int PH_DRAIN = 3;
   localparam int PH_DONE  = 4;

   logic             clk = 1'b0;
   logic             resetn, start, lock, stop, wrvalid, rdready;
   logic             wa, ena, enb, enwr, enrd, ensteer, resetaddr, complete;
   logic [ADDRW-1:0] wraddr, rdaddr;
   logic [2:0]       selectline;

   int vectors = 0;
   int miscompares = 0;

   pingpong_sched #(.DEPTH(DEPTH), .ADDRW(ADDRW), .LANES(LANES)) dut (
      .clk(clk), .resetn(resetn), .start(start), .lock(lock), .stop(stop),
      .wrvalid(wrvalid), .rdready(rdready), .wa(wa), .ena(ena), .enb(enb),
      .enwr(enwr), .enrd(enrd), .wraddr(wraddr), .rdaddr(rdaddr),
      .selectline(selectline), .ensteer(ensteer), .resetaddr(resetaddr),
      .complete(complete)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: words held in the write bank and lanes taken from the read bank.
   int m_ph = PH_IDLE, m_wa = 1, m_wc = 0, m_rc = 0, m_stop = 0, m_ra = 0, m_cp = 0;

   always @(negedge clk) begin
      int e_wr, e_st, e_rd, sw, old_stop;
      if (!resetn) begin
         m_ph = PH_IDLE; m_wa = 1; m_wc = 0; m_rc = 0;
         m_stop = 0; m_ra = 0; m_cp = 0;
      end
      e_wr = (lock && wrvalid && m_wc < DEPTH && (m_ph == PH_FILL || m_ph == PH_PP)) ? 1 : 0;
      e_st = (lock && rdready && m_rc < TOTAL && (m_ph == PH_PP || m_ph == PH_DRAIN)) ? 1 : 0;
      e_rd = (e_st == 1 && (m_rc % LANES) == 0) ? 1 : 0;
      chk("wa", int'(wa), m_wa);
      chk("enwr", int'(enwr), e_wr);
      chk("ensteer", int'(ensteer), e_st);
      chk("enrd", int'(enrd), e_rd);
      chk("ena", int'(ena), m_wa ? e_wr : e_rd);
      chk("enb", int'(enb), m_wa ? e_rd : e_wr);
      chk("wraddr", int'(wraddr), m_wc % DEPTH);
      chk("rdaddr", int'(rdaddr), (m_rc / LANES) % DEPTH);
      chk("selectline", int'(selectline), m_rc % LANES);
      chk("resetaddr", int'(resetaddr), m_ra);
      chk("complete", int'(complete), m_cp);
      if (resetn) begin
         sw = (lock && m_wc == DEPTH &&
               (m_ph == PH_FILL || (m_ph == PH_PP && m_rc == TOTAL))) ? 1 : 0;
         old_stop = m_stop;
         m_ra = sw;
         m_cp = (lock && m_ph == PH_DRAIN && m_rc == TOTAL) ? 1 : 0;
         if (m_ph == PH_IDLE) m_stop = 0;
         else if (lock && stop) m_stop = 1;
         if (sw == 1) begin
            m_wa = 1 - m_wa;
            m_wc = 0;
            m_rc = 0;
            m_ph = old_stop ? PH_DRAIN : PH_PP;
         end else begin
            m_wc += e_wr;
            m_rc += e_st;
            case (m_ph)
               PH_IDLE:  if (lock && start) begin m_ph = PH_FILL; m_wc = 0; m_rc = 0; end
               PH_DRAIN: if (m_cp == 1) m_ph = PH_DONE;
               PH_DONE:  m_ph = PH_IDLE;
               default:  ;
            endcase
         end
      end
   end

   initial begin
      int got, drain, nst, nwr;
      resetn  = 1'b0;
      start   = 1'(($urandom_range(0, 1)));
      lock    = 1'(($urandom_range(0, 1)));
      stop    = 1'(($urandom_range(0, 1)));
      wrvalid = 1'(($urandom_range(0, 1)));
      rdready = 1'(($urandom_range(0, 1)));
      repeat (3) @(posedge clk);
      #1 start = 1'b1; wrvalid = 1'b1; rdready = 1'b1; lock = 1'b1;
      @(negedge clk);
      chk("rst_wa", int'(wa), 1);
      chk("rst_wraddr", int'(wraddr), 0);
      chk("rst_strobes", int'({ena, enb, enwr, enrd, ensteer}), 0);

      @(posedge clk); #1;
      resetn = 1'b1; start = 1'b0; lock = 1'b1; stop = 1'b0;
      wrvalid = 1'b0; rdready = 1'b0;
      repeat (2) @(posedge clk); #1;

      // fill: first bank is A
      start = 1'b1; wrvalid = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk("fill_enwr", int'(enwr), 1);
         chk("fill_ena", int'(ena), 1);
         chk("fill_wraddr", int'(wraddr), i);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("swap_enwr", int'(enwr), 0);
      chk("swap_wa_old", int'(wa), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_swap_wa", int'(wa), 0);
      chk("post_swap_resetaddr", int'(resetaddr), 1);

      // steady state: drain A lane by lane while B fills and then stalls
      @(posedge clk); #1 rdready = 1'b1;
      for (int i = 0; i < TOTAL; i++) begin
         @(negedge clk);
         chk("ss_ensteer", int'(ensteer), 1);
         chk("ss_selectline", int'(selectline), i % 4);
         chk("ss_rdaddr", int'(rdaddr), i / 4);
         chk("ss_ena_rd", int'(ena), (i % 4 == 0) ? 1 : 0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("ss_swap_strobes", int'({enwr, ensteer}), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ss2_wa", int'(wa), 1);
      chk("ss2_resetaddr", int'(resetaddr), 1);
      chk("ss2_wraddr", int'(wraddr), 0);

      // lock drop with wraddr at 5
      repeat (5) @(posedge clk);
      #1 lock = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("lock_wraddr", int'(wraddr), 5);
         chk("lock_strobes", int'({ena, enb, enwr, enrd, ensteer}), 0);
         @(posedge clk); #1;
      end
      lock = 1'b1;
      @(negedge clk);
      chk("resume_enwr", int'(enwr), 1);
      chk("resume_wraddr", int'(wraddr), 5);

      // stop: finish bank, drain, complete
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      got = 0; drain = 0; nst = 0; nwr = 0;
      for (int c = 0; c < 300 && got == 0; c++) begin
         @(negedge clk);
         if (resetaddr) drain = 1;
         if (drain == 1) begin nst += int'(ensteer); nwr += int'(enwr); end
         if (complete) got = 1;
         else begin @(posedge clk); #1; end
      end
      chk("complete_seen", got, 1);
      chk("drain_lanes", nst, TOTAL);
      chk("drain_writes", nwr, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("complete_one_cycle", int'(complete), 0);
      chk("idle_strobes", int'({ena, enb, enwr, enrd, ensteer}), 0);

      // second run: write bank is B this time
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("run2_enb", int'(enb), 1);
      chk("run2_ena", int'(ena), 0);
      chk("run2_wraddr", int'(wraddr), 0);

      got = 0;
      for (int c = 0; c < 300 && got == 0; c++) begin
         @(negedge clk);
         if (rdaddr == 3'd3) got = 1;
      end
      chk("rdaddr3_seen", got, 1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_wa", int'(wa), 1);
      chk("arst_addrs", int'({wraddr, rdaddr, selectline}), 0);
      chk("arst_outs", int'({ena, enb, enwr, enrd, ensteer, resetaddr, complete}), 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pingpong_sched.md
# pingpong_sched

Single-clock scheduler for the two-bank (A/B) ping-pong buffer datapath. One bank is filled by the writer while the other is drained lane-by-lane through the output steering mux; roles swap when the write bank is full and the read bank is empty. Generates bank enables, write/read addresses, steering select and frame-completion status. Sits between the input stream, the A/B memories and the steering mux.

## Interface
- DEPTH, 8, words per bank (power of 2, ≥2)
- ADDRW, 3, log2(DEPTH)
- LANES, 4, sub-lanes steered out per word (2..8)
- clk  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin operation (sampled in IDLE only)
- lock  in  1  clock-lock qualifier; low freezes block
- stop  in  1  end after current fill; sticky once sampled high
- wrvalid  in  1  input word available
- rdready  in  1  consumer accepts one lane this cycle
- wa  out  1  1: A is write bank, B is read bank
- ena, enb  out  1 each  bank A/B enable
- enwr  out  1  write strobe to write bank
- enrd  out  1  word fetch from read bank
- wraddr, rdaddr  out  ADDRW each  bank addresses
- selectline  out  3  steering lane index
- ensteer  out  1  steering output valid
- resetaddr  out  1  one-cycle pulse after each swap
- complete  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, FILL, PINGPONG, DRAIN, DONE.
- IDLE→FILL: start & lock. FILL→PINGPONG on swap (or →DRAIN if stop latched). PINGPONG→DRAIN on swap with stop latched. DRAIN→DONE when read bank empty. DONE→IDLE unconditionally.
- enwr = lock & wrvalid & !wrfull & state∈{FILL,PINGPONG}; wraddr increments on enwr; write of address DEPTH-1 sets wrfull.
- ensteer = lock & rdready & !rdempty & state∈{PINGPONG,DRAIN}; selectline increments on ensteer, wraps LANES-1→0; rdaddr increments when selectline wraps; last lane of address DEPTH-1 sets rdempty.
- enrd = ensteer & (selectline==0).
- ena = wa ? enwr : enrd; enb = wa ? enrd : enwr.
- Swap: FILL: wrfull; PINGPONG: wrfull & rdempty. On swap: wa toggles, wraddr/rdaddr/selectline←0, wrfull←0, rdempty←0. In DRAIN-bound swap, write side stays idle.
- No enable is active in a swap cycle (both sides already stalled).
- lock low: all strobes 0, state/counters/flags hold; start ignored.
- start outside IDLE ignored. stop latched in any non-IDLE state, cleared in IDLE. Partial bank at stop is held until full; no short frame.
- Counters wrap modulo DEPTH / LANES; no overflow possible.

## Timing
- Reset values: state IDLE, wa=1, wraddr=rdaddr=0, selectline=0, all strobes and flags 0, complete=0, resetaddr=0.
- Strobes ena/enb/enwr/enrd/ensteer combinational from registered state and inputs; all other outputs registered.
- Fill: DEPTH enwr cycles, swap on the next cycle, resetaddr high the cycle after swap.
- Drain: DEPTH×LANES ensteer cycles per bank.
- complete high exactly one cycle (DONE), the cycle after rdempty set in DRAIN.
- Async reset mid-operation returns all outputs to reset values immediately; no pending stop survives.

## Structure
- Package pingpong_pkg: state enum, default DEPTH/ADDRW/LANES constants.
- Sub-module bank_counter (enable, clear, wrap value, terminal flag), instantiated for wraddr, rdaddr and selectline.

## Test plan
- Reset: resetn low with random inputs -> wa=1, all addresses 0, all strobes 0.
- Fill: start=lock=wrvalid=1 -> 8 enwr/ena cycles, wraddr 0..7; next cycle wa=0; following cycle resetaddr=1.
- Steady state: rdready=wrvalid=1 -> 32 ensteer cycles, selectline 0,1,2,3 repeating, enrd on every 4th with enb=1 pattern on A/B per wa, rdaddr 0..7; writes stall after 8 words until swap.
- Lock drop: lock=0 after wraddr=5 for 10 cycles -> no strobes, wraddr stays 5; resumes at 5 when lock=1.
- Stop: stop pulse mid-PINGPONG -> writes finish bank, swap to DRAIN, 32 lanes out, complete one cycle, return IDLE; second start works.
- Reset mid-PINGPONG at rdaddr=3 -> immediate reset values, state IDLE.
